// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline. It drives the pipeline register
// we/zero pairs and the PC enable, tracks I/D-cache refills and keeps saturating stall/redirect counters.
module pipeline_hazard_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cnt_clr,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd,
   input  logic             ex_branch_taken,
   input  logic             icache_miss,
   input  logic             icache_done,
   input  logic             dcache_miss,
   input  logic             dcache_done,
   output logic             pc_we,
   output logic             if_id_we,
   output logic             if_id_zero,
   output logic             id_ex_we,
   output logic             id_ex_zero,
   output logic             ex_mem_we,
   output logic             ex_mem_zero,
   output logic             mem_wb_we,
   output logic             mem_wb_zero,
   output logic [1:0]       miss_state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] redirect_cnt
);

   // Encoding is {d_pend, i_pend}
   typedef enum logic [1:0] {
      RUN    = 2'b00,
      IWAIT  = 2'b01,
      DWAIT  = 2'b10,
      DIWAIT = 2'b11
   } miss_state_t;

   miss_state_t state, state_nx;
   logic        i_act, d_act, load_use, redirect;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= state_nx;
   end

   always_comb begin
      i_act    = (state[0] | icache_miss) & ~icache_done;
      d_act    = (state[1] | dcache_miss) & ~dcache_done;
      state_nx = miss_state_t'({d_act, i_act});
   end

   assign miss_state = state;

   assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));

   always_comb begin
      pc_we       = 1'b1;
      if_id_we    = 1'b1;
      if_id_zero  = 1'b0;
      id_ex_we    = 1'b1;
      id_ex_zero  = 1'b0;
      ex_mem_we   = 1'b1;
      ex_mem_zero = 1'b0;
      mem_wb_we   = 1'b1;
      mem_wb_zero = 1'b0;
      redirect    = 1'b0;
      if (rst) begin
         pc_we     = 1'b0;
         if_id_we  = 1'b0;
         id_ex_we  = 1'b0;
         ex_mem_we = 1'b0;
         mem_wb_we = 1'b0;
      end else if (d_act) begin
         pc_we       = 1'b0;
         if_id_we    = 1'b0;
         id_ex_we    = 1'b0;
         ex_mem_we   = 1'b0;
         mem_wb_zero = 1'b1;
      end else if (ex_branch_taken && i_act) begin
         // Branch stays parked in EX until the fetch side can accept the redirect
         pc_we       = 1'b0;
         if_id_we    = 1'b0;
         id_ex_we    = 1'b0;
         ex_mem_zero = 1'b1;
      end else if (ex_branch_taken) begin
         if_id_zero = 1'b1;
         id_ex_zero = 1'b1;
         redirect   = 1'b1;
      end else if (load_use) begin
         pc_we      = 1'b0;
         if_id_we   = 1'b0;
         id_ex_zero = 1'b1;
      end else if (i_act) begin
         pc_we      = 1'b0;
         if_id_zero = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt    <= '0;
         redirect_cnt <= '0;
      end else if (cnt_clr) begin
         stall_cnt    <= '0;
         redirect_cnt <= '0;
      end else begin
         if (!pc_we && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (redirect && redirect_cnt != '1)
            redirect_cnt <= redirect_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (CNT_W=4); expectations are queued when each
// cycle's stimulus is applied and popped when the outputs are sampled mid-cycle.
module tb_pipeline_hazard_ctrl;
   localparam int CW = 4;

   // {pc_we, if_id_we/zero, id_ex_we/zero, ex_mem_we/zero, mem_wb_we/zero}
   localparam logic [8:0] NORM = 9'b1_10_10_10_10;
   localparam logic [8:0] RSTV = 9'b0_00_00_00_00;
   localparam logic [8:0] R2   = 9'b0_00_00_00_11;
   localparam logic [8:0] R3   = 9'b0_00_00_11_10;
   localparam logic [8:0] R4   = 9'b1_11_11_10_10;
   localparam logic [8:0] R5   = 9'b0_00_11_10_10;
   localparam logic [8:0] R6   = 9'b0_11_10_10_10;

   logic clk, rst, cnt_clr;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
   logic icache_miss, icache_done, dcache_miss, dcache_done;
   logic pc_we, if_id_we, if_id_zero, id_ex_we, id_ex_zero;
   logic ex_mem_we, ex_mem_zero, mem_wb_we, mem_wb_zero;
   logic [1:0] miss_state;
   logic [CW-1:0] stall_cnt, redirect_cnt;
   logic [8:0] obs_ctrl;

   typedef struct {
      string         tag;
      logic [8:0]    ctrl;
      logic [1:0]    ms;
      logic [CW-1:0] sc;
      logic [CW-1:0] rc;
   } exp_t;

   exp_t q[$];
   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [CW-1:0] m_stall = '0;
   logic [CW-1:0] m_redir = '0;

   pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .cnt_clr(cnt_clr),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
      .icache_miss(icache_miss), .icache_done(icache_done),
      .dcache_miss(dcache_miss), .dcache_done(dcache_done),
      .pc_we(pc_we), .if_id_we(if_id_we), .if_id_zero(if_id_zero),
      .id_ex_we(id_ex_we), .id_ex_zero(id_ex_zero),
      .ex_mem_we(ex_mem_we), .ex_mem_zero(ex_mem_zero),
      .mem_wb_we(mem_wb_we), .mem_wb_zero(mem_wb_zero),
      .miss_state(miss_state), .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
   );

   assign obs_ctrl = {pc_we, if_id_we, if_id_zero, id_ex_we, id_ex_zero,
                      ex_mem_we, ex_mem_zero, mem_wb_we, mem_wb_zero};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      cnt_clr = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      ex_mem_read = 0; ex_rd = 0; ex_branch_taken = 0;
      icache_miss = 0; icache_done = 0; dcache_miss = 0; dcache_done = 0;
   endtask

   task automatic cmp(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] ex);
      checks++;
      assert (obs === ex) else begin
         errors++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, ex);
      end
   endtask

   // Called right after the cycle's inputs are applied
   task automatic chk(input string tag, input logic [8:0] ctrl, input logic [1:0] ms);
      exp_t e, g;
      if (rst) begin
         m_stall = '0;
         m_redir = '0;
      end
      e.tag = tag; e.ctrl = ctrl; e.ms = ms; e.sc = m_stall; e.rc = m_redir;
      q.push_back(e);
      #3;
      g = q.pop_front();
      cmp(g.tag, "ctrl", 32'(obs_ctrl), 32'(g.ctrl));
      cmp(g.tag, "miss_state", 32'(miss_state), 32'(g.ms));
      cmp(g.tag, "stall_cnt", 32'(stall_cnt), 32'(g.sc));
      cmp(g.tag, "redirect_cnt", 32'(redirect_cnt), 32'(g.rc));
      // Counter model for the value visible after the next rising edge
      if (!rst) begin
         if (cnt_clr) begin
            m_stall = '0;
            m_redir = '0;
         end else begin
            if (!ctrl[8] && m_stall != '1) m_stall = m_stall + 1'b1;
            if (ctrl == R4 && m_redir != '1) m_redir = m_redir + 1'b1;
         end
      end
   endtask

   initial begin
      rst = 1; clr_in();
      #2;
      chk("reset", RSTV, 2'b00);
      tick(); rst = 0; chk("post_rst", NORM, 2'b00);

      // Load-use on rs1, then x0 and rs2 variants
      tick(); ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; chk("lu_rs1", R5, 2'b00);
      tick(); clr_in(); chk("lu_after", NORM, 2'b00);
      tick(); ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1; chk("lu_x0", NORM, 2'b00);
      tick(); clr_in(); ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; chk("lu_rs2", R5, 2'b00);
      tick(); id_use_rs2 = 0; chk("lu_rs2_unused", NORM, 2'b00);

      // I-miss for 4 cycles, done on the 5th
      tick(); clr_in(); icache_miss = 1; chk("imiss_t", R6, 2'b00);
      tick(); icache_miss = 0; chk("imiss_t1", R6, 2'b01);
      tick(); chk("imiss_t2", R6, 2'b01);
      tick(); chk("imiss_t3", R6, 2'b01);
      tick(); icache_done = 1; chk("imiss_done", NORM, 2'b01);
      tick(); icache_done = 0; chk("imiss_idle", NORM, 2'b00);
      tick(); icache_done = 1; chk("stray_done", NORM, 2'b00);

      // Concurrent D and I misses; I finishes first
      tick(); clr_in(); icache_miss = 1; dcache_miss = 1; chk("di_t5", R2, 2'b00);
      tick(); clr_in(); chk("di_t6", R2, 2'b11);
      tick(); icache_done = 1; chk("di_t7", R2, 2'b11);
      tick(); clr_in(); chk("di_t8", R2, 2'b10);
      tick(); dcache_done = 1; chk("di_t9", NORM, 2'b10);
      tick(); clr_in(); chk("di_idle", NORM, 2'b00);

      // Branch held in EX during IWAIT
      tick(); icache_miss = 1; chk("br_t0", R6, 2'b00);
      tick(); icache_miss = 0; ex_branch_taken = 1; chk("br_t1", R3, 2'b01);
      tick(); chk("br_t2", R3, 2'b01);
      tick(); icache_done = 1; chk("br_t3", R4, 2'b01);
      tick(); clr_in(); chk("br_idle", NORM, 2'b00);

      // Branch beats load-use
      tick(); ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
      chk("br_lu", R4, 2'b00);

      // D-miss arriving during IWAIT
      tick(); clr_in(); icache_miss = 1; chk("dwi_t0", R6, 2'b00);
      tick(); icache_miss = 0; dcache_miss = 1; chk("dwi_t1", R2, 2'b01);
      tick(); dcache_miss = 0; chk("dwi_t2", R2, 2'b11);
      tick(); icache_done = 1; chk("dwi_t3", R2, 2'b11);
      tick(); icache_done = 0; dcache_done = 1; chk("dwi_t4", NORM, 2'b10);
      tick(); clr_in(); chk("dwi_idle", NORM, 2'b00);

      // Counter clear, then saturation of stall_cnt
      tick(); cnt_clr = 1; chk("clr", NORM, 2'b00);
      for (int i = 0; i < 20; i++) begin
         tick(); clr_in(); ex_mem_read = 1; ex_rd = 9; id_rs2 = 9; id_use_rs2 = 1;
         chk("sat", R5, 2'b00);
      end
      tick(); cnt_clr = 1; chk("sat_clr", R5, 2'b00);
      tick(); clr_in(); chk("sat_cleared", NORM, 2'b00);

      // Reset in the middle of a D refill; late done must be ignored
      tick(); dcache_miss = 1; chk("rd_t0", R2, 2'b00);
      tick(); dcache_miss = 0; chk("rd_t1", R2, 2'b10);
      tick(); rst = 1; chk("rd_rst", RSTV, 2'b00);
      tick(); rst = 0; dcache_done = 1; chk("rd_late_done", NORM, 2'b00);
      tick(); clr_in(); chk("rd_idle", NORM, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage pipeline with instruction and data caches. Each cycle it drives the `we`/`zero` pair of every pipeline register (IF_ID, ID_EX, EX_MEM, MEM_WB) plus the PC write enable. It tracks outstanding I-cache and D-cache refills with a small state machine and keeps saturating performance counters.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous reset, active-high
- cnt_clr  in  1  synchronous clear of the counters
- id_rs1, id_rs2  in  5 each  source register numbers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1 each  the instruction in ID actually reads rs1 / rs2
- ex_mem_read  in  1  the instruction in EX is a load
- ex_rd  in  5  destination register of the instruction in EX
- ex_branch_taken  in  1  branch/jump in EX resolved taken; redirect required
- icache_miss  in  1  I-cache lookup missed this cycle (level, 1 cycle)
- icache_done  in  1  I-cache refill complete; fetch data valid this cycle (1-cycle pulse)
- dcache_miss, dcache_done  in  1 each  same protocol for the D-cache, MEM stage
- pc_we  out  1  PC write enable
- if_id_we, if_id_zero  out  1 each  IF_ID load enable / load-zero (bubble)
- id_ex_we, id_ex_zero, ex_mem_we, ex_mem_zero, mem_wb_we, mem_wb_zero  out  1 each  same for the other stage registers
- miss_state  out  2  {d_pend, i_pend} registered refill state
- stall_cnt, redirect_cnt  out  CNT_W each  performance counters

## Operation
- Pipeline register contract:
  - we=1, zero=0: load.
  - we=1, zero=1: load all-zero (bubble).
  - we=0: hold.
- State: two registered flags, i_pend and d_pend. The four states are RUN=00, IWAIT=01, DWAIT=10, DIWAIT=11.
- Effective pending:
  - I_act = (i_pend | icache_miss) & ~icache_done.
  - D_act = (d_pend | dcache_miss) & ~dcache_done.
  - A `done` with no pending miss is ignored.
- Next state: i_pend <= I_act; d_pend <= D_act. Both flags update independently.
- Outputs are combinational from state and inputs. The first matching rule wins; "normal" means we=1, zero=0.
  1. rst high: all we=0, all zero=0.
  2. D_act: pc_we, if_id_we, id_ex_we, ex_mem_we = 0; mem_wb_we=1, mem_wb_zero=1.
  3. ex_branch_taken & I_act: pc_we, if_id_we, id_ex_we = 0; ex_mem_we=1, ex_mem_zero=1; MEM_WB normal. The branch is held in EX until the refill finishes.
  4. ex_branch_taken: pc_we=1; IF_ID and ID_EX we=1, zero=1; EX_MEM and MEM_WB normal.
  5. Load-use: ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)). Response: pc_we=0, if_id_we=0; ID_EX we=1, zero=1; rest normal.
  6. I_act: pc_we=0; IF_ID we=1, zero=1; rest normal.
  7. Otherwise all normal.
- Counters:
  - stall_cnt increments in every non-reset cycle with pc_we=0.
  - redirect_cnt increments in every rule-4 cycle.
  - Both saturate at 2^CNT_W-1.
  - cnt_clr has priority over increment; the counter reads 0 the next cycle.
- Register x0 never causes a load-use stall.

## Timing
- Reset: i_pend=d_pend=0, counters=0, miss_state=00. While rst is high, all we/zero outputs are 0.
- Deasserting rst yields rule 7 in the next cycle when no inputs are active.
- Stall/flush outputs have zero latency (same cycle as the inputs). State and counters have 1-cycle latency.
- Miss at cycle t, done at cycle t+n:
  - Stall covers t..t+n-1.
  - Cycle t+n flows normally, unless a lower-priority rule applies.
  - miss_state is non-zero for cycles t+1..t+n.
- Simultaneous D and I misses: enter DIWAIT. The I-refill may finish first; rule 2 still dominates until D is done.
- A D-miss arriving during IWAIT: go to DIWAIT; the front stages remain frozen.
- Reset mid-refill clears both flags immediately (asynchronous). Any later `done` pulse is ignored.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for 1 cycle -> pc_we=0, if_id_we=0, id_ex_we=1, id_ex_zero=1, stall_cnt 0->1. Repeat with ex_rd=0 -> all normal.
- I-miss: icache_miss at cycle 10, icache_done at cycle 14 -> cycles 10-13 show pc_we=0 and IF_ID bubble; miss_state=01 during 11-14; cycle 14 normal; stall_cnt=4.
- D-miss with concurrent I-miss: both misses at cycle 5, icache_done at 7, dcache_done at 9 -> rule 2 for cycles 5-8; miss_state 11 for 6-7, then 10 for 8-9; cycle 9 normal.
- Branch during IWAIT: I-miss at cycle 0, ex_branch_taken held from cycle 1, done at 3 -> cycles 1-2 show EX_MEM bubble and front frozen; cycle 3 shows pc_we=1 with IF_ID/ID_EX flushed; redirect_cnt=1.
- Branch plus load-use in the same cycle -> rule 4 wins: pc_we=1, IF_ID/ID_EX flushed, no stall counted.
- Counter saturation with CNT_W=4: 20 stall cycles -> stall_cnt=15. cnt_clr -> 0 next cycle. rst asserted mid-DWAIT -> miss_state=00 immediately and the later dcache_done is ignored.
